qif_spike_decoder: RTL

//  Consumer side of the QIF neuron's membrane-voltage output. Samples the 8-bit signed V stream

---
 rtl/qif_pkg.sv | 15 +
 rtl/qif_spike_detect.sv | 42 ++++
 rtl/qif_spike_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/qif_pkg.sv
// ----------------------------------------------------------------------------------------------
// qif_pkg
//   Constants and types shared between the QIF neuron and its consumers.
//   - qif_v_t : 8-bit two's-complement membrane voltage
//   - V_RESET : voltage the neuron snaps to after firing
//   - V_PEAK  : firing threshold
// ----------------------------------------------------------------------------------------------
package qif_pkg;

    typedef logic signed [7:0] qif_v_t;

    localparam qif_v_t V_RESET = -8'sd20;
    localparam qif_v_t V_PEAK  = 8'sd50;

endpackage

// File: rtl/qif_spike_detect.sv
// ----------------------------------------------------------------------------------------------
// qif_spike_detect
//   Registers the membrane-voltage stream and flags a firing event: previous sample at or above
//   V_PEAK followed by a sample equal to V_RESET.
//   Ports:
//     clk            clock (posedge)
//     rst_n          synchronous reset, active-high
//     v_i            membrane voltage sample
//     spike_det_o    combinational detect for the sample currently on v_i
//     spike_pulse_o  registered one-cycle strobe, high the cycle after the reset sample
// ----------------------------------------------------------------------------------------------
module qif_spike_detect
    import qif_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] v_i,
    output logic       spike_det_o,
    output logic       spike_pulse_o
);

    qif_v_t v_q;
    qif_v_t v_s;
    logic   spike_pulse_q;

    assign v_s         = qif_v_t'(v_i);
    assign spike_det_o = (v_q >= V_PEAK) && (v_s == V_RESET);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            // Seeding with V_RESET guarantees no spike on the first sample after reset.
            v_q           <= V_RESET;
            spike_pulse_q <= 1'b0;
        end else begin
            v_q           <= v_s;
            spike_pulse_q <= spike_det_o;
        end
    end

    assign spike_pulse_o = spike_pulse_q;

endmodule

// File: rtl/qif_spike_decoder.sv
// ----------------------------------------------------------------------------------------------
// qif_spike_decoder
//   Decodes the QIF spike train into a per-window spike count and the latest inter-spike
//   interval, delivered through a valid/ready output register.
//   Ports:
//     clk, rst_n            clock; synchronous active-high reset
//     enable                1 = decoding; 0 = idle with window/ISI state cleared
//     v_in                  membrane voltage (signed)
//     spike_pulse           one-cycle strobe per detected spike
//     out_valid/out_ready   result handshake
//     spike_count           spikes in the completed window (saturating)
//     last_isi              most recent ISI in cycles (saturating)
//     isi_valid             at least two spikes seen since enable rose
//     overrun               sticky: a window result was dropped
// ----------------------------------------------------------------------------------------------
module qif_spike_decoder
    import qif_pkg::*;
#(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned ISI_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       v_in,
    output logic             spike_pulse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] spike_count,
    output logic [ISI_W-1:0] last_isi,
    output logic             isi_valid,
    output logic             overrun
);

    localparam int unsigned      WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ISI_W-1:0] ISI_MAX  = '1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             spike_det;
    logic             state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d, isi_inc;
    logic [ISI_W-1:0] isi_reg_q, isi_reg_d;
    logic             seen_q, seen_d;
    logic             isi_ok_q, isi_ok_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic [ISI_W-1:0] isi_out_q, isi_out_d;
    logic             iv_out_q, iv_out_d;
    logic             overrun_q, overrun_d;
    logic             active, close;

    qif_spike_detect u_detect (
        .clk           (clk),
        .rst_n         (rst_n),
        .v_i           (v_in),
        .spike_det_o   (spike_det),
        .spike_pulse_o (spike_pulse)
    );

    // A RUN cycle with enable low is already treated as idle, so a window whose close cycle
    // sees enable low is aborted without a result.
    assign active  = (state_q == ST_RUN) && enable;
    assign close   = active && (win_q == WIN_LAST);
    assign acc_inc = (spike_det && (acc_q != CNT_MAX)) ? acc_q + CNT_W'(1) : acc_q;
    assign isi_inc = (isi_cnt_q != ISI_MAX) ? isi_cnt_q + ISI_W'(1) : isi_cnt_q;

    always_comb begin
        state_d     = enable ? ST_RUN : ST_IDLE;
        win_d       = '0;
        acc_d       = '0;
        isi_cnt_d   = '0;
        isi_reg_d   = '0;
        seen_d      = 1'b0;
        isi_ok_d    = 1'b0;
        out_valid_d = out_valid_q;
        cnt_out_d   = cnt_out_q;
        isi_out_d   = isi_out_q;
        iv_out_d    = iv_out_q;
        overrun_d   = overrun_q;

        if (active) begin
            win_d     = close ? '0 : win_q + WIN_W'(1);
            // A spike on the close cycle is part of acc_inc and so belongs to the closing window.
            acc_d     = close ? '0 : acc_inc;
            isi_cnt_d = isi_inc;
            isi_reg_d = isi_reg_q;
            seen_d    = seen_q;
            isi_ok_d  = isi_ok_q;
            if (spike_det) begin
                isi_cnt_d = '0;
                seen_d    = 1'b1;
                if (seen_q) begin
                    isi_reg_d = isi_inc;
                    isi_ok_d  = 1'b1;
                end
            end
        end

        if (close) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                cnt_out_d   = acc_inc;
                isi_out_d   = isi_reg_d;
                iv_out_d    = isi_ok_d;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            acc_q       <= '0;
            isi_cnt_q   <= '0;
            isi_reg_q   <= '0;
            seen_q      <= 1'b0;
            isi_ok_q    <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_out_q   <= '0;
            isi_out_q   <= '0;
            iv_out_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            acc_q       <= acc_d;
            isi_cnt_q   <= isi_cnt_d;
            isi_reg_q   <= isi_reg_d;
            seen_q      <= seen_d;
            isi_ok_q    <= isi_ok_d;
            out_valid_q <= out_valid_d;
            cnt_out_q   <= cnt_out_d;
            isi_out_q   <= isi_out_d;
            iv_out_q    <= iv_out_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign spike_count = cnt_out_q;
    assign last_isi    = isi_out_q;
    assign isi_valid   = iv_out_q;
    assign overrun     = overrun_q;

endmodule
